// File: rtl/crc16_frame_ctrl.sv
// Round-robin frame arbiter in front of a CRC-16/CCITT-FALSE engine.
// Passes granted payload bytes through, then appends the CRC MSB first.

module crc16_CCITT (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_reset,
    input  logic        crc_en,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // One byte through the MSB-first LFSR
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        crc_out <= CRC_INIT;
        else if (sync_reset) crc_out <= CRC_INIT;
        else if (crc_en)     crc_out <= crc_byte(crc_out, data_in);
    end
endmodule

module crc16_frame_ctrl #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req_valid,
    input  logic [7:0]           req_data0,
    input  logic [7:0]           req_data1,
    input  logic [1:0]           req_last,
    output logic [1:0]           req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 out_src,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic [15:0]          crc_value
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_DATA, S_WAIT, S_CRC_HI, S_CRC_LO
    } state_t;

    localparam logic [LEN_WIDTH-1:0] CNT_MAX = {LEN_WIDTH{1'b1}};

    state_t               state, state_nxt;
    logic                 rr;
    logic [LEN_WIDTH-1:0] cnt;
    logic [15:0]          crc_out;
    logic                 sync_reset_c, crc_en_c, grant_c, grant_src_c, done_c;
    logic                 sel_valid_c, sel_last_c;
    logic [7:0]           sel_data_c;

    crc16_CCITT u_crc (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset_c),
        .crc_en     (crc_en_c),
        .data_in    (sel_data_c),
        .crc_out    (crc_out)
    );

    // Only the granted requester is visible past this point
    assign sel_valid_c = out_src ? req_valid[1] : req_valid[0];
    assign sel_last_c  = out_src ? req_last[1]  : req_last[0];
    assign sel_data_c  = out_src ? req_data1    : req_data0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        out_last     = 1'b0;
        req_ready    = 2'b00;
        sync_reset_c = 1'b0;
        crc_en_c     = 1'b0;
        grant_c      = 1'b0;
        grant_src_c  = 1'b0;
        done_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_c     = 1'b1;
                    grant_src_c = (req_valid == 2'b11) ? rr : req_valid[1];
                    state_nxt   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                sync_reset_c = 1'b1;
                state_nxt    = S_DATA;
            end
            S_DATA: begin
                out_valid = sel_valid_c;
                out_data  = sel_data_c;
                req_ready = out_src ? {out_ready, 1'b0} : {1'b0, out_ready};
                crc_en_c  = sel_valid_c & out_ready;
                if (crc_en_c && sel_last_c) state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_CRC_HI;
            S_CRC_HI: begin
                out_valid = 1'b1;
                out_data  = crc_out[15:8];
                if (out_ready) state_nxt = S_CRC_LO;
            end
            S_CRC_LO: begin
                out_valid = 1'b1;
                out_data  = crc_out[7:0];
                out_last  = 1'b1;
                if (out_ready) begin
                    done_c    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, byte counter and completed-frame results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_src    <= 1'b0;
            rr         <= 1'b0;
            cnt        <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            crc_value  <= 16'h0000;
        end else begin
            frame_done <= done_c;
            if (grant_c) begin
                out_src <= grant_src_c;
                rr      <= ~grant_src_c;
            end
            if (sync_reset_c)                     cnt <= '0;
            else if (crc_en_c && cnt != CNT_MAX)  cnt <= cnt + LEN_WIDTH'(1);
            if (done_c) begin
                frame_len <= cnt;
                crc_value <= crc_out;
            end
        end
    end
endmodule
